// File: rtl/dyn_clkgen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dyn_clkgen_pkg : shared types and constants for the DCM_CLKGEN     |
// | reprogramming controller.                 Rev 1.0                  |
// +--------------------------------------------------------------------+
package dyn_clkgen_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD_D    = 4'd1,
    S_GAP_D     = 4'd2,
    S_LOAD_M    = 4'd3,
    S_GAP_M     = 4'd4,
    S_GO        = 4'd5,
    S_WAIT_DONE = 4'd6,
    S_WAIT_LOCK = 4'd7,
    S_DCM_RST   = 4'd8,
    S_FAIL      = 4'd9
  } state_e;

  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_LOAD_M = 2'b11;
  localparam int         WORD_LEN   = 10;
  localparam int         FIELD_W    = WORD_LEN - 2;
  localparam int         GAP_LEN    = 2;

  // Command bits occupy the LSBs so they leave the shifter first.
  function automatic logic [WORD_LEN-1:0] make_word(input logic [1:0]         cmd,
                                                    input logic [FIELD_W-1:0] val_m1);
    return {val_m1, cmd};
  endfunction

endpackage
`default_nettype wire

// File: rtl/clkgen_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | clkgen_shifter : LSB-first load-word shifter with bit counter.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module clkgen_shifter
  import dyn_clkgen_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_i,
  input  logic                shift_i,
  input  logic [WORD_LEN-1:0] word_i,
  output logic                bit_o,
  output logic                last_bit_o
);

  localparam int BIT_W = $clog2(WORD_LEN);

  logic [WORD_LEN-1:0] word_q;
  logic [BIT_W-1:0]    cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      word_q <= word_i;
      cnt_q  <= '0;
    end else if (shift_i) begin
      word_q <= {1'b0, word_q[WORD_LEN-1:1]};
      cnt_q  <= cnt_q + BIT_W'(1);
    end
  end

  assign bit_o      = word_q[0];
  assign last_bit_o = (cnt_q == BIT_W'(WORD_LEN - 1));

endmodule
`default_nettype wire

// File: rtl/dyn_clkgen_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dyn_clkgen_ctrl : DCM_CLKGEN reprogramming controller with lock    |
// | supervision, DCM reset/retry and idle watchdog.   Rev 1.0          |
// +--------------------------------------------------------------------+
module dyn_clkgen_ctrl
  import dyn_clkgen_pkg::*;
#(
  parameter int OSC_MHZ      = 100,
  parameter int SPEED_MHZ    = 25,
  parameter int SPEED_MIN    = 2,
  parameter int SPEED_MAX    = 100,
  parameter int VAL_W        = 8,
  parameter int PROG_DIV     = 1,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int MAX_RETRY    = 3,
  parameter int RST_CYCLES   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_valid,
  input  logic [VAL_W-1:0] speed_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic             rejected,
  output logic [VAL_W-1:0] cur_speed,
  output logic             progclk,
  output logic             progen,
  output logic             progdata,
  input  logic             progdone,
  input  logic             locked,
  input  logic [2:1]       status,
  output logic             dcm_reset
);

  localparam int CNT_MAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 2);
  localparam int DIV_W   = $clog2(PROG_DIV + 1);

  localparam logic [VAL_W-1:0] SPD_MIN = VAL_W'(SPEED_MIN);
  localparam logic [VAL_W-1:0] SPD_MAX = VAL_W'(SPEED_MAX);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [RTY_W-1:0]   retry_q;
  logic [VAL_W-1:0]   target_q, cur_speed_q;
  logic [DIV_W-1:0]   div_q;
  logic               progclk_q, progen_q, progdata_q, dcm_reset_q;
  logic               done_q, rejected_q, fail_q;

  logic                w_fall, w_accept, w_lock_ok;
  logic                w_sh_load, w_sh_shift, w_bit, w_last;
  logic [WORD_LEN-1:0] w_sh_word;
  logic                w_unused_status;

  // status[1] (CLKIN stopped) plays no part in any decision here.
  assign w_unused_status = status[1];

  assign w_fall    = (div_q == DIV_W'(PROG_DIV - 1)) && progclk_q;
  assign w_accept  = start && (speed_in >= SPD_MIN) && (speed_in <= SPD_MAX);
  assign w_lock_ok = locked && !status[2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q     <= '0;
      progclk_q <= 1'b0;
    end else if (div_q == DIV_W'(PROG_DIV - 1)) begin
      div_q     <= '0;
      progclk_q <= ~progclk_q;
    end else begin
      div_q     <= div_q + DIV_W'(1);
    end
  end

  // Shifter preloads the next word while not shifting; the M word is staged during GAP_D.
  assign w_sh_load  = (state_q != S_LOAD_D) && (state_q != S_LOAD_M);
  assign w_sh_shift = w_fall && !w_sh_load;
  assign w_sh_word  = (state_q == S_GAP_D)
                    ? make_word(CMD_LOAD_M, FIELD_W'(target_q - VAL_W'(1)))
                    : make_word(CMD_LOAD_D, FIELD_W'(OSC_MHZ - 1));

  clkgen_shifter u_shifter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (w_sh_load),
    .shift_i    (w_sh_shift),
    .word_i     (w_sh_word),
    .bit_o      (w_bit),
    .last_bit_o (w_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      target_q    <= VAL_W'(SPEED_MHZ);
      cur_speed_q <= VAL_W'(SPEED_MHZ);
      progen_q    <= 1'b0;
      progdata_q  <= 1'b0;
      dcm_reset_q <= 1'b0;
      done_q      <= 1'b0;
      rejected_q  <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rejected_q <= 1'b0;
      if (!clk_valid) begin
        state_q     <= S_IDLE;
        cnt_q       <= '0;
        retry_q     <= '0;
        progen_q    <= 1'b0;
        progdata_q  <= 1'b0;
        dcm_reset_q <= 1'b0;
      end else begin
        if (w_fall) begin
          progen_q   <= 1'b0;
          progdata_q <= 1'b0;
        end
        case (state_q)
          S_IDLE, S_FAIL: begin
            if (w_accept) begin
              target_q <= speed_in;
              retry_q  <= '0;
              fail_q   <= 1'b0;
              cnt_q    <= '0;
              state_q  <= S_LOAD_D;
            end else begin
              if (start) rejected_q <= 1'b1;
              if (state_q == S_IDLE) begin
                if (w_lock_ok) begin
                  cnt_q <= '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                  target_q    <= cur_speed_q;
                  retry_q     <= '0;
                  cnt_q       <= '0;
                  dcm_reset_q <= 1'b1;
                  state_q     <= S_DCM_RST;
                end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                end
              end
            end
          end
          S_LOAD_D, S_LOAD_M: if (w_fall) begin
            progen_q   <= 1'b1;
            progdata_q <= w_bit;
            if (w_last) begin
              cnt_q   <= '0;
              state_q <= (state_q == S_LOAD_D) ? S_GAP_D : S_GAP_M;
            end
          end
          S_GAP_D, S_GAP_M: if (w_fall) begin
            if (cnt_q == CNT_W'(GAP_LEN - 1)) begin
              cnt_q   <= '0;
              state_q <= (state_q == S_GAP_D) ? S_LOAD_M : S_GO;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_GO: if (w_fall) begin
            progen_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_WAIT_DONE;
          end
          S_WAIT_DONE, S_WAIT_LOCK: begin
            if ((state_q == S_WAIT_DONE) ? progdone : w_lock_ok) begin
              cnt_q <= '0;
              if (state_q == S_WAIT_DONE) begin
                state_q <= S_WAIT_LOCK;
              end else begin
                done_q      <= 1'b1;
                cur_speed_q <= target_q;
                state_q     <= S_IDLE;
              end
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
              cnt_q       <= '0;
              dcm_reset_q <= 1'b1;
              state_q     <= S_DCM_RST;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_DCM_RST: begin
            if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
              cnt_q       <= '0;
              dcm_reset_q <= 1'b0;
              if (retry_q < RTY_W'(MAX_RETRY)) begin
                retry_q <= retry_q + RTY_W'(1);
                state_q <= S_LOAD_D;
              end else begin
                fail_q  <= 1'b1;
                state_q <= S_FAIL;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_FAIL);
  assign done      = done_q;
  assign fail      = fail_q;
  assign rejected  = rejected_q;
  assign cur_speed = cur_speed_q;
  assign progclk   = progclk_q;
  assign progen    = progen_q;
  assign progdata  = progdata_q;
  assign dcm_reset = dcm_reset_q;

endmodule
`default_nettype wire

// File: tb/tb_dyn_clkgen_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dyn_clkgen_ctrl : directed bench for dyn_clkgen_ctrl.  Rev 1.0  |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_dyn_clkgen_ctrl;

  logic       clk = 1'b0, reset_n = 1'b0, clk_valid = 1'b1, start = 1'b0;
  logic       progdone = 1'b0, locked = 1'b1;
  logic [7:0] speed_in = 8'd0;
  logic [2:1] status = 2'b00;
  logic       busy, done, fail, rejected, progclk, progen, progdata, dcm_reset;
  logic [7:0] cur_speed;

  dyn_clkgen_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk_valid (clk_valid),
    .speed_in  (speed_in),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .rejected  (rejected),
    .cur_speed (cur_speed),
    .progclk   (progclk),
    .progen    (progen),
    .progdata  (progdata),
    .progdone  (progdone),
    .locked    (locked),
    .status    (status),
    .dcm_reset (dcm_reset)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0, n_bad = 0;
  logic bits[$];
  int   rst_w = 0, rst_pulses = 0, rst_badw = 0;

  // The DCM samples PROGEN/PROGDATA on the rising edge of PROGCLK.
  always @(posedge progclk) if (progen) bits.push_back(progdata);

  always @(negedge clk) begin
    if (dcm_reset) begin
      rst_w = rst_w + 1;
    end else if (rst_w != 0) begin
      rst_pulses = rst_pulses + 1;
      if (rst_w != 8) rst_badw = rst_badw + 1;
      rst_w = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] word_at(input int base);
    logic [9:0] w;
    for (int i = 0; i < 10; i++) w[i] = bits[base + i];
    return w;
  endfunction

  task automatic wait_bits(input int n, input int limit, input string tag);
    int k = 0;
    while (bits.size() < n && k < limit) begin
      tick(1);
      k++;
    end
    check_val({tag, "_bits"}, 32'(bits.size() >= n), 1);
  endtask

  task automatic send_start(input logic [7:0] spd, input logic drop_lock);
    speed_in = spd;
    start    = 1'b1;
    if (drop_lock) locked = 1'b0;
    tick(1);
    start    = 1'b0;
  endtask

  // Plays the DCM: PROGDONE after the GO, then LOCKED; optionally pokes start in WAIT_LOCK.
  task automatic finish_xfer(input string tag, input logic [9:0] exp_m, input logic poke,
                             output logic [7:0] spd_at_done);
    logic seen = 1'b0;
    spd_at_done = 8'hxx;
    wait_bits(21, 300, tag);
    check_val({tag, "_dword"}, 32'(word_at(0)), 397);
    check_val({tag, "_mword"}, 32'(word_at(10)), 32'(exp_m));
    check_val({tag, "_gobit"}, 32'(bits[20]), 0);
    tick(3);
    progdone = 1'b1;
    tick(2);
    progdone = 1'b0;
    if (poke) begin
      speed_in = 8'd30;
      start    = 1'b1;
      tick(1);
      start    = 1'b0;
      check_val({tag, "_poke_busy"}, 32'(busy), 1);
      check_val({tag, "_poke_rej"}, 32'(rejected), 0);
      tick(2);
    end
    tick(2);
    locked = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        seen        = 1'b1;
        spd_at_done = cur_speed;
        break;
      end
      tick(1);
    end
    check_val({tag, "_done"}, 32'(seen), 1);
    tick(1);
    check_val({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    logic [7:0] spd;
    logic [7:0] bad_spd [3];
    int         lat, base_p, base_bad, k;
    logic       seen;

    bad_spd[0] = 8'd0;
    bad_spd[1] = 8'd101;
    bad_spd[2] = 8'd1;

    // Reset state
    tick(4);
    check_val("rst_progclk", 32'(progclk), 0);
    check_val("rst_progen", 32'(progen), 0);
    check_val("rst_progdata", 32'(progdata), 0);
    check_val("rst_dcm_reset", 32'(dcm_reset), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_fail", 32'(fail), 0);
    check_val("rst_rejected", 32'(rejected), 0);
    check_val("rst_cur_speed", 32'(cur_speed), 25);
    reset_n = 1'b1;
    tick(3);

    // Nominal transfer to 50 MHz
    bits.delete();
    send_start(8'd50, 1'b1);
    check_val("x50_busy", 32'(busy), 1);
    lat = 0;
    while (!progen && lat < 10) begin
      tick(1);
      lat++;
    end
    check_val("x50_start_lat", 32'(lat >= 1 && lat <= 2), 1);
    finish_xfer("x50", 10'd199, 1'b0, spd);
    check_val("x50_cur_speed", 32'(spd), 50);
    check_val("x50_busy_end", 32'(busy), 0);

    // Out-of-range requests
    for (int i = 0; i < 3; i++) begin
      send_start(bad_spd[i], 1'b0);
      check_val("rej_pulse", 32'(rejected), 1);
      check_val("rej_busy", 32'(busy), 0);
      check_val("rej_progen", 32'(progen), 0);
      tick(1);
      check_val("rej_pulse_end", 32'(rejected), 0);
    end

    // clk_valid drop in the middle of LOAD_M
    bits.delete();
    send_start(8'd40, 1'b0);
    wait_bits(13, 200, "cv");
    check_val("cv_progen_before", 32'(progen), 1);
    clk_valid = 1'b0;
    tick(1);
    check_val("cv_progen", 32'(progen), 0);
    check_val("cv_busy", 32'(busy), 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) seen = 1'b1;
      tick(1);
    end
    check_val("cv_no_done", 32'(seen), 0);
    check_val("cv_cur_speed", 32'(cur_speed), 50);
    clk_valid = 1'b1;
    tick(6);
    check_val("cv_idle", 32'(busy), 0);

    // Idle watchdog: 4096 cycles without lock forces a reprogram at cur_speed
    bits.delete();
    locked = 1'b0;
    tick(4095);
    check_val("wd_before_rst", 32'(dcm_reset), 0);
    check_val("wd_before_busy", 32'(busy), 0);
    tick(1);
    check_val("wd_rst", 32'(dcm_reset), 1);
    check_val("wd_busy", 32'(busy), 1);
    finish_xfer("wd", 10'd199, 1'b0, spd);
    check_val("wd_cur_speed", 32'(spd), 50);

    // start during WAIT_LOCK is ignored; top of range accepted
    bits.delete();
    send_start(8'd100, 1'b1);
    finish_xfer("x100", 10'd399, 1'b1, spd);
    check_val("x100_cur_speed", 32'(spd), 100);
    tick(10);
    check_val("x100_no_restart", 32'(busy), 0);
    check_val("x100_bit_count", 32'(bits.size()), 21);

    // Never locks: four attempts, then FAIL
    bits.delete();
    base_p   = rst_pulses;
    base_bad = rst_badw;
    send_start(8'd60, 1'b1);
    wait_bits(64, 15000, "retry4");
    check_val("retry_pulses_between", 32'(rst_pulses - base_p), 3);
    k = 0;
    while (!fail && k < 6000) begin
      tick(1);
      k++;
    end
    check_val("retry_fail", 32'(fail), 1);
    tick(2);
    check_val("retry_busy", 32'(busy), 0);
    check_val("retry_dcm_reset", 32'(dcm_reset), 0);
    check_val("retry_bit_count", 32'(bits.size()), 84);
    check_val("retry_pulses_total", 32'(rst_pulses - base_p), 4);
    check_val("retry_pulse_width", 32'(rst_badw - base_bad), 0);
    check_val("retry_last_mword", 32'(word_at(73)), 239);
    check_val("retry_cur_speed", 32'(cur_speed), 100);

    // Recovery from FAIL at the bottom of the range
    bits.delete();
    send_start(8'd2, 1'b0);
    check_val("min2_fail_clear", 32'(fail), 0);
    check_val("min2_busy", 32'(busy), 1);
    finish_xfer("min2", 10'd7, 1'b0, spd);
    check_val("min2_cur_speed", 32'(spd), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
